input_vc_unit: RTL

Input-port VC buffer and switch-allocation requester for one router input port. It sits on the request side of the separable switch allocator. It stores incoming flits in per-VC FIFOs and latches each packet's output port from its head flit. It drives one `vc_request`/`vc_target_port` row into the allocator, and when granted it dequeues one flit to the crossbar and returns a credit upstream.

---
 rtl/input_vc_unit_if.sv | 57 +++++
 rtl/input_vc_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/input_vc_unit_if.sv
// ---------------------------------------------------------------------------
// input_vc_unit_if
//   Signal bundle between one router input port's VC unit and its
//   surroundings: the upstream flit write channel, the switch-allocator
//   request/grant row and the registered crossbar/credit outputs.
//
//   modport slave  : the input VC unit itself
//   modport master : upstream link, allocator and crossbar (e.g. a testbench)
//
//   Signals:
//     in_valid/in_vc/in_head/in_tail/in_dst/in_data  flit write channel
//     port_ready[PORT_NUM]       downstream credit available per output port
//     vc_request[VC_NUM]         allocator request row
//     vc_target_port[VC_NUM]     latched output port per VC
//     vc_grant[VC_NUM]           allocator grant row
//     out_valid/out_port/out_head/out_tail/out_data  dequeued flit
//     credit_out[VC_NUM]         one-cycle credit return pulse per VC
// ---------------------------------------------------------------------------
interface input_vc_unit_if #(
  parameter int VC_NUM   = 2,
  parameter int FLIT_W   = 32,
  parameter int PORT_NUM = 5
);
  localparam int VC_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int PORT_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  logic                          in_valid;
  logic [VC_W-1:0]               in_vc;
  logic                          in_head;
  logic                          in_tail;
  logic [PORT_W-1:0]             in_dst;
  logic [FLIT_W-1:0]             in_data;
  logic [PORT_NUM-1:0]           port_ready;
  logic [VC_NUM-1:0]             vc_request;
  logic [VC_NUM-1:0][PORT_W-1:0] vc_target_port;
  logic [VC_NUM-1:0]             vc_grant;
  logic                          out_valid;
  logic [PORT_W-1:0]             out_port;
  logic                          out_head;
  logic                          out_tail;
  logic [FLIT_W-1:0]             out_data;
  logic [VC_NUM-1:0]             credit_out;

  modport master (
    output in_valid, in_vc, in_head, in_tail, in_dst, in_data,
    output port_ready, vc_grant,
    input  vc_request, vc_target_port,
    input  out_valid, out_port, out_head, out_tail, out_data, credit_out
  );

  modport slave (
    input  in_valid, in_vc, in_head, in_tail, in_dst, in_data,
    input  port_ready, vc_grant,
    output vc_request, vc_target_port,
    output out_valid, out_port, out_head, out_tail, out_data, credit_out
  );
endinterface

// File: rtl/input_vc_unit.sv
// ---------------------------------------------------------------------------
// input_vc_unit
//   Input-port VC buffer and switch-allocation requester. Each VC owns a FIFO
//   of {head, tail, dst, data} entries and a two-state FSM (IDLE/ACTIVE).
//   When a head flit reaches the FIFO front of an IDLE VC, its dst is latched
//   into vc_target_port and the VC becomes ACTIVE. An ACTIVE, non-empty VC
//   whose target port has downstream credit raises vc_request. The lowest
//   granted requesting VC pops one flit, which appears registered on out_*
//   one cycle later together with a credit_out pulse for that VC.
//
//   Ports:
//     clk    clock
//     RSTn   asynchronous active-low reset
//     err    sticky protocol error (only when IVU_ERR_CHECK_EN is defined)
//     bus    input_vc_unit_if.slave (flit input, allocator row, outputs)
//
//   Build option:
//     IVU_ERR_CHECK_EN  adds the err port and its checks: write to a full
//                       FIFO, non-head flit at the front of an IDLE VC,
//                       grant bit outside vc_request, multi-bit grant.
// ---------------------------------------------------------------------------
module input_vc_unit #(
  parameter int VC_NUM    = 2,
  parameter int BUF_DEPTH = 4,
  parameter int FLIT_W    = 32,
  parameter int PORT_NUM  = 5
) (
  input  logic           clk,
  input  logic           RSTn,
`ifdef IVU_ERR_CHECK_EN
  output logic           err,
`endif
  input_vc_unit_if.slave bus
);
  localparam int VC_W    = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int PORT_W  = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int PTR_W   = $clog2(BUF_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENT_W   = 2 + PORT_W + FLIT_W;
  // port_ready widened to every value a latched dst can take, so an
  // out-of-range dst simply never sees credit.
  localparam int READY_W = 1 << PORT_W;

  typedef enum logic { IDLE = 1'b0, ACTIVE = 1'b1 } vc_state_t;

  logic [READY_W-1:0]            ready_ext;
  logic [VC_NUM-1:0]             request;
  logic [VC_NUM-1:0]             win;
  logic [VC_W-1:0]               win_idx;
  logic                          win_any;
  logic [VC_NUM-1:0]             front_head;
  logic [VC_NUM-1:0]             front_tail;
  logic [VC_NUM-1:0][FLIT_W-1:0] front_data;
  logic [VC_NUM-1:0][PORT_W-1:0] target_port;
`ifdef IVU_ERR_CHECK_EN
  logic [VC_NUM-1:0]             idle_bad;
  logic [VC_NUM-1:0]             wr_full;
`endif

  assign ready_ext = READY_W'(bus.port_ready);

  // Only grants that land on a requesting VC count; of those the lowest
  // index wins so a malformed multi-bit grant still pops a single flit.
  always_comb begin
    win     = '0;
    win_idx = '0;
    win_any = 1'b0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (!win_any && bus.vc_grant[v] && request[v]) begin
        win[v]  = 1'b1;
        win_idx = VC_W'(v);
        win_any = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < VC_NUM; gi++) begin : g_vc
    logic [ENT_W-1:0]  mem [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    vc_state_t         state_reg;
    vc_state_t         state_next;
    logic [PORT_W-1:0] target_reg;
    logic [ENT_W-1:0]  front_entry;
    logic              front_is_head;
    logic              front_is_tail;
    logic              not_empty;
    logic              not_full;
    logic              push;
    logic              pop;
    logic              start;

    assign front_entry   = mem[rd_ptr_reg];
    assign front_is_head = front_entry[ENT_W-1];
    assign front_is_tail = front_entry[ENT_W-2];
    assign not_empty     = (count_reg != '0);
    // Fullness is judged on the count before this cycle's pop, so a write
    // to a full FIFO is lost even when the same VC is draining.
    assign not_full      = (count_reg < CNT_W'(BUF_DEPTH));
    assign push          = bus.in_valid && (bus.in_vc == VC_W'(gi)) && not_full;
    assign pop           = win[gi];
    assign count_next    = count_reg + CNT_W'(push) - CNT_W'(pop);

    assign front_head[gi]  = front_is_head;
    assign front_tail[gi]  = front_is_tail;
    assign front_data[gi]  = front_entry[FLIT_W-1:0];
    assign target_port[gi] = target_reg;
    assign request[gi]     = (state_reg == ACTIVE) && not_empty && ready_ext[target_reg];

`ifdef IVU_ERR_CHECK_EN
    assign idle_bad[gi] = (state_reg == IDLE) && not_empty && !front_is_head;
    assign wr_full[gi]  = bus.in_valid && (bus.in_vc == VC_W'(gi)) && !not_full;
`endif

    // Storage has no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
      if (push) begin
        mem[wr_ptr_reg] <= {bus.in_head, bus.in_tail, bus.in_dst, bus.in_data};
      end
    end

    always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        count_reg <= count_next;
      end
    end

    always_comb begin
      state_next = state_reg;
      start      = 1'b0;
      case (state_reg)
        IDLE: begin
          // A non-head flit at the front keeps the VC parked in IDLE.
          if (not_empty && front_is_head) begin
            state_next = ACTIVE;
            start      = 1'b1;
          end
        end
        ACTIVE: begin
          if (pop && front_is_tail) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end

    // target_reg keeps the last packet's port after the VC returns to IDLE.
    always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
        state_reg  <= IDLE;
        target_reg <= '0;
      end else begin
        state_reg <= state_next;
        if (start) target_reg <= front_entry[ENT_W-3 -: PORT_W];
      end
    end
  end

  logic              out_valid_reg;
  logic [PORT_W-1:0] out_port_reg;
  logic              out_head_reg;
  logic              out_tail_reg;
  logic [FLIT_W-1:0] out_data_reg;
  logic [VC_NUM-1:0] credit_reg;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      out_valid_reg <= 1'b0;
      out_port_reg  <= '0;
      out_head_reg  <= 1'b0;
      out_tail_reg  <= 1'b0;
      out_data_reg  <= '0;
      credit_reg    <= '0;
    end else begin
      out_valid_reg <= win_any;
      credit_reg    <= win;
      if (win_any) begin
        out_port_reg <= target_port[win_idx];
        out_head_reg <= front_head[win_idx];
        out_tail_reg <= front_tail[win_idx];
        out_data_reg <= front_data[win_idx];
      end
    end
  end

  assign bus.vc_request     = request;
  assign bus.vc_target_port = target_port;
  assign bus.out_valid      = out_valid_reg;
  assign bus.out_port       = out_port_reg;
  assign bus.out_head       = out_head_reg;
  assign bus.out_tail       = out_tail_reg;
  assign bus.out_data       = out_data_reg;
  assign bus.credit_out     = credit_reg;

`ifdef IVU_ERR_CHECK_EN
  logic err_reg;
  logic err_event;

  assign err_event = (|wr_full) || (|idle_bad) ||
                     (|(bus.vc_grant & ~request)) ||
                     ($countones(bus.vc_grant) > 1);

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) err_reg <= 1'b0;
    else       err_reg <= err_reg | err_event;
  end

  assign err = err_reg;
`endif
endmodule
